// File: rtl/collatz_step_pkg.sv
// Shared constants and types for the single-step Collatz responder and its
// trajectory driver counterpart.
package collatz_step_pkg;

  localparam int          COLLATZ_WIDTH    = 32;
  localparam logic [31:0] COLLATZ_ERR_VAL  = 32'h0000_0000;
  localparam logic [31:0] COLLATZ_TRAJ_ERR = 32'h2BAD_2BAD;

  typedef enum logic [1:0] {
    STEP_HALVE,
    STEP_TRIPLE,
    STEP_OVF
  } step_kind_e;

endpackage

// File: rtl/collatz_step_if.sv
// AXI-Stream style data channel used for both the num and collatz streams.
interface collatz_step_if
  import collatz_step_pkg::*;
#(
  parameter int WIDTH = COLLATZ_WIDTH
) ();

  logic [WIDTH-1:0] TDATA;
  logic             TVALID;
  logic             TREADY;

  modport master (output TDATA, output TVALID, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);

endinterface

// File: rtl/collatz_fifo.sv
// Synchronous FIFO with registered pointers; the head reads as zero when empty
// so the stream data is clean while invalid and during reset.
module collatz_fifo
  import collatz_step_pkg::*;
#(
  parameter int WIDTH = COLLATZ_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en, pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked until an entry is written.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/collatz_step.sv
// Single-step Collatz responder: one input register, inline step arithmetic,
// and an output FIFO guarded by a credit count of everything in flight.
module collatz_step
  import collatz_step_pkg::*;
#(
  parameter int WIDTH      = COLLATZ_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  collatz_step_if.slave         num,
  collatz_step_if.master        collatz,
  input  logic                  stats_clr,
  output logic [31:0]           step_count,
  output logic [15:0]           ovf_count,
  output logic                  busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             run_q, run_d;
  logic [31:0]      step_count_q, step_count_d;
  logic [15:0]      ovf_count_q, ovf_count_d;

  logic             num_hs, out_hs;
  logic [WIDTH+1:0] triple;
  step_kind_e       kind;
  logic [WIDTH-1:0] result;
  logic [AW:0]      fifo_count;
  logic             fifo_empty, fifo_full;
  logic [AW+1:0]    credit_used;

  // Ready depends on registers only, and stays low until the first edge after reset.
  assign credit_used     = (AW+2)'(fifo_count) + (AW+2)'(s1_vld_q);
  assign num.TREADY      = run_q && !fifo_full && (credit_used < (AW+2)'(FIFO_DEPTH));
  assign num_hs          = num.TVALID && num.TREADY;
  assign out_hs          = collatz.TVALID && collatz.TREADY;
  assign collatz.TVALID  = !fifo_empty;
  assign busy            = s1_vld_q || !fifo_empty;
  assign step_count      = step_count_q;
  assign ovf_count       = ovf_count_q;
  assign run_d           = 1'b1;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    if (num_hs) begin
      s1_vld_d  = 1'b1;
      s1_data_d = num.TDATA;
    end else if (s1_vld_q) begin
      s1_vld_d  = 1'b0;
    end
  end

  // 3n+1 is formed two bits wide so any carry out of WIDTH flags overflow.
  always_comb begin
    triple = {2'b00, s1_data_q} + {1'b0, s1_data_q, 1'b0} + (WIDTH+2)'(1);
    kind   = STEP_HALVE;
    result = s1_data_q >> 1;
    if (s1_data_q[0]) begin
      if (triple[WIDTH+1:WIDTH] != 2'b00) begin
        kind   = STEP_OVF;
        result = WIDTH'(COLLATZ_ERR_VAL);
      end else begin
        kind   = STEP_TRIPLE;
        result = triple[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    step_count_d = step_count_q;
    ovf_count_d  = ovf_count_q;
    if (stats_clr) begin
      step_count_d = '0;
      ovf_count_d  = '0;
    end else begin
      if (out_hs && step_count_q != '1)
        step_count_d = step_count_q + 32'd1;
      if (s1_vld_q && kind == STEP_OVF && ovf_count_q != '1)
        ovf_count_d = ovf_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q     <= 1'b0;
      s1_data_q    <= '0;
      run_q        <= 1'b0;
      step_count_q <= '0;
      ovf_count_q  <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_data_q    <= s1_data_d;
      run_q        <= run_d;
      step_count_q <= step_count_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  collatz_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s1_vld_q),
    .push_data (result),
    .pop       (out_hs),
    .head      (collatz.TDATA),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
